// File: rtl/bp_probe_stimulus.sv
// BytePipe-programmable pseudo-random probe generator: one Galois LFSR and
// threshold per channel, with optional odd-from-even channel pairing.
//   state | meaning
//   IDLE  | waiting for command byte (b7=1 write, b7=0 read)
//   WDATA | next upstream byte is written to the latched address
//   RRESP | read byte presented downstream until accepted
module bp_probe_stimulus #(
  parameter int         N_PROBE    = 4,
  parameter logic [7:0] RESET_SEED = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  input  logic [7:0]         i_bp_data,
  input  logic               i_bp_valid,
  output logic               o_bp_ready,
  output logic [7:0]         o_bp_data,
  output logic               o_bp_valid,
  input  logic               i_bp_ready,
  output logic [N_PROBE-1:0] o_probe
);

  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, WDATA, RRESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [6:0]          addr;
  logic                en;
  logic                pair;
  logic [7:0]          seed;
  logic [7:0]          thresh [N_PROBE];
  logic [15:0]         lfsr   [N_PROBE];
  logic                up_fire;
  logic                dn_fire;
  logic                wr_fire;
  logic                seed_wr;
  logic [7:0]          rd_mux;
  logic [N_PROBE:0]    probe_shl;
  logic [N_PROBE-1:0]  probe_nxt;

  function automatic logic [15:0] seed_load(input logic [7:0] s, input int ch);
    logic [15:0] v;
    v = {s, ~s} ^ 16'(ch + 1);
    if (v == 16'h0000) v = 16'h0001;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  assign up_fire = i_bp_valid && o_bp_ready && i_cg;
  assign dn_fire = o_bp_valid && i_bp_ready && i_cg;
  assign wr_fire = up_fire && (state == WDATA);
  assign seed_wr = wr_fire && (addr == 7'd1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (up_fire) state_nxt = i_bp_data[7] ? WDATA : RRESP;
      WDATA:   if (up_fire) state_nxt = IDLE;
      RRESP:   if (dn_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_bp_ready = (state != RRESP);
    o_bp_valid = (state == RRESP);
  end

  always_comb begin
    rd_mux = 8'h00;
    if (i_bp_data[6:0] == 7'd0)        rd_mux = {6'b0, pair, en};
    else if (i_bp_data[6:0] == 7'd1)   rd_mux = seed;
    else if (i_bp_data[6:0] == 7'd127) rd_mux = 8'(N_PROBE);
    for (int ch = 0; ch < N_PROBE; ch++)
      if (i_bp_data[6:0] == 7'(ch + 2)) rd_mux = thresh[ch];
  end

  // Read data is snapshotted at command accept so it cannot change while pending.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr      <= '0;
      o_bp_data <= '0;
    end else if (up_fire && state == IDLE) begin
      addr <= i_bp_data[6:0];
      if (!i_bp_data[7]) o_bp_data <= rd_mux;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      en   <= 1'b0;
      pair <= 1'b0;
      seed <= RESET_SEED;
      for (int ch = 0; ch < N_PROBE; ch++) thresh[ch] <= '0;
    end else if (wr_fire) begin
      if (addr == 7'd0) begin
        en   <= i_bp_data[0];
        pair <= i_bp_data[1];
      end
      if (addr == 7'd1) seed <= i_bp_data;
      for (int ch = 0; ch < N_PROBE; ch++)
        if (addr == 7'(ch + 2)) thresh[ch] <= i_bp_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int ch = 0; ch < N_PROBE; ch++) lfsr[ch] <= seed_load(RESET_SEED, ch);
    end else if (seed_wr) begin
      for (int ch = 0; ch < N_PROBE; ch++) lfsr[ch] <= seed_load(i_bp_data, ch);
    end else if (i_cg && en) begin
      for (int ch = 0; ch < N_PROBE; ch++) lfsr[ch] <= lfsr_step(lfsr[ch]);
    end
  end

  // probe_shl[ch] is the previous channel's registered pulse, used for pairing.
  assign probe_shl = {o_probe, 1'b0};

  always_comb begin
    probe_nxt = '0;
    for (int ch = 0; ch < N_PROBE; ch++)
      if (en)
        probe_nxt[ch] = (pair && (ch % 2 == 1)) ? probe_shl[ch]
                                                : (lfsr[ch][7:0] < thresh[ch]);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    o_probe <= '0;
    else if (i_cg) o_probe <= probe_nxt;
  end

endmodule

// File: tb/tb_bp_probe_stimulus.sv
// Directed bench for bp_probe_stimulus: register access over BytePipe plus a
// reference LFSR that predicts probe pulses cycle by cycle.
module tb_bp_probe_stimulus;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cg = 1'b1;
  logic [7:0] bp_data_in;
  logic       bp_valid_in;
  logic       bp_ready_out;
  logic [7:0] bp_data_out;
  logic       bp_valid_out;
  logic       bp_ready_in;
  logic [3:0] probe;

  int vectors = 0;
  int miscompares = 0;
  bit gap_mode = 1'b0;
  int pcount [4];
  logic [3:0] trace_cur [256];
  logic [3:0] trace_ref [256];

  bp_probe_stimulus #(.N_PROBE(4), .RESET_SEED(8'hA5)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_cg       (cg),
    .i_bp_data  (bp_data_in),
    .i_bp_valid (bp_valid_in),
    .o_bp_ready (bp_ready_out),
    .o_bp_data  (bp_data_out),
    .o_bp_valid (bp_valid_out),
    .i_bp_ready (bp_ready_in),
    .o_probe    (probe)
  );

  always #5 clk = ~clk;

  // Clock-enable gaps: roughly one cycle in ten low while gap_mode is set.
  always @(posedge clk) begin
    #2;
    cg = gap_mode ? ($urandom_range(0, 9) != 0) : 1'b1;
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_mode) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bp_data_in  = b;
    bp_valid_in = 1'b1;
    n = 0;
    while (!(bp_ready_out === 1'b1 && cg === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bp_valid_in = 1'b0;
    check("send_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    send_byte({1'b1, a});
    send_byte(d);
  endtask

  task automatic read_check(input logic [6:0] a, input logic [7:0] exp, input string tag);
    int n;
    send_byte({1'b0, a});
    @(negedge clk);
    check({tag, "_valid"}, 32'(bp_valid_out), 32'd1);
    check(tag, 32'(bp_data_out), 32'(exp));
    if (gap_mode) repeat ($urandom_range(0, 3)) @(negedge clk);
    bp_ready_in = 1'b1;
    n = 0;
    while (cg !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bp_ready_in = 1'b0;
    check({tag, "_done"}, 32'(bp_valid_out), 32'd0);
  endtask

  // Runs `cycles` clocks, predicting channel ch from a reference LFSR and
  // requiring the whole probe vector to hold on cycles with the enable low.
  task automatic run_check(input int cycles, input int ch, input logic [7:0] th,
                           input logic [15:0] init, output int mism);
    logic [15:0] s;
    logic        c;
    logic [3:0]  prev;
    s = init;
    mism = 0;
    for (int k = 0; k < 4; k++) pcount[k] = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      c    = cg;
      prev = probe;
      @(posedge clk);
      #1;
      if (c) begin
        if (probe[ch] !== (s[7:0] < th)) mism++;
        s = ref_step(s);
      end else if (probe !== prev) begin
        mism++;
      end
      for (int k = 0; k < 4; k++) pcount[k] += int'(probe[k]);
      if (i < 256) trace_cur[i] = probe;
    end
  endtask

  initial begin
    int m;
    int bad;
    int pm;
    int cnt;
    logic [15:0] s;
    logic prev0;

    rst_n       = 1'b0;
    bp_data_in  = 8'h00;
    bp_valid_in = 1'b0;
    bp_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bp_ready_out), 32'd1);
    check("rst_valid", 32'(bp_valid_out), 32'd0);
    check("rst_data", 32'(bp_data_out), 32'h00);
    check("rst_probe", 32'(probe), 32'h0);
    rst_n = 1'b1;

    // ID and CTRL reads, probes idle while disabled
    read_check(7'd127, 8'h04, "rd_id");
    read_check(7'd0, 8'h00, "rd_ctrl_rst");
    read_check(7'd1, 8'hA5, "rd_seed_rst");
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (probe !== 4'h0) bad++;
    end
    check("idle_probe_zero", 32'(bad), 32'd0);

    // Full-density ch0, silent ch1
    write_reg(7'd2, 8'hFF);
    write_reg(7'd3, 8'h00);
    write_reg(7'd0, 8'h01);
    run_check(4096, 0, 8'hFF, 16'hA55B, m);
    check("t2_ch0_trace", 32'(m), 32'd0);
    check("t2_ch0_density", 32'(pcount[0] >= 4056), 32'd1);
    check("t2_ch1_count", 32'(pcount[1]), 32'd0);

    // Quarter density on ch2, reproducible from the same seed
    write_reg(7'd0, 8'h00);
    write_reg(7'd4, 8'h40);
    write_reg(7'd1, 8'hA5);
    write_reg(7'd0, 8'h01);
    run_check(65536, 2, 8'h40, 16'hA559, m);
    check("t3_ch2_trace", 32'(m), 32'd0);
    check("t3_ch2_density", 32'(pcount[2] >= 15565 && pcount[2] <= 17203), 32'd1);
    for (int i = 0; i < 256; i++) trace_ref[i] = trace_cur[i];
    write_reg(7'd0, 8'h00);
    write_reg(7'd1, 8'hA5);
    write_reg(7'd0, 8'h01);
    run_check(256, 2, 8'h40, 16'hA559, m);
    check("t3_rerun_trace", 32'(m), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (trace_cur[i] !== trace_ref[i]) bad++;
    check("t3_same_seed_repeat", 32'(bad), 32'd0);

    // Pair mode: ch1 follows ch0 one cycle late
    write_reg(7'd0, 8'h00);
    write_reg(7'd2, 8'h80);
    write_reg(7'd1, 8'hA5);
    write_reg(7'd0, 8'h03);
    s = 16'hA55B;
    prev0 = probe[0];
    m = 0;
    pm = 0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (probe[1] !== prev0) pm++;
      if (probe[0] !== (s[7:0] < 8'h80)) m++;
      cnt += int'(probe[0]);
      s = ref_step(s);
      prev0 = probe[0];
    end
    check("t4_pair_lag", 32'(pm), 32'd0);
    check("t4_ch0_trace", 32'(m), 32'd0);
    check("t4_ch0_active", 32'(cnt > 0 && cnt < 300), 32'd1);

    // Stalled read response holds and blocks upstream
    send_byte({1'b0, 7'd1});
    bp_data_in  = 8'h80;
    bp_valid_in = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(bp_valid_out === 1'b1 && bp_data_out === 8'hA5 && bp_ready_out === 1'b0)) bad++;
    end
    check("t5_stall_hold", 32'(bad), 32'd0);
    check("t5_stall_data", 32'(bp_data_out), 32'hA5);
    bp_valid_in = 1'b0;
    bp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    bp_ready_in = 1'b0;
    check("t5_released", 32'(bp_valid_out), 32'd0);
    read_check(7'd0, 8'h03, "t5_ctrl_untouched");

    // Enable gaps, extreme seeds, out-of-range address
    gap_mode = 1'b1;
    write_reg(7'd0, 8'h00);
    write_reg(7'd2, 8'h80);
    write_reg(7'd3, 8'h80);
    write_reg(7'd4, 8'h80);
    write_reg(7'd5, 8'h80);
    write_reg(7'd1, 8'h00);
    write_reg(7'd0, 8'h01);
    run_check(400, 0, 8'h80, 16'h00FE, m);
    check("t6_seed00_trace", 32'(m), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("t6_seed00_ch%0d_alive", k), 32'(pcount[k] > 0), 32'd1);
    write_reg(7'd0, 8'h00);
    write_reg(7'd1, 8'hFF);
    write_reg(7'd0, 8'h01);
    run_check(400, 3, 8'h80, 16'hFF04, m);
    check("t6_seedff_trace", 32'(m), 32'd0);
    write_reg(7'd100, 8'h55);
    read_check(7'd100, 8'h00, "t6_rd_addr100");
    read_check(7'd5, 8'h80, "t6_rd_thresh3");
    read_check(7'd1, 8'hFF, "t6_rd_seed");
    gap_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during a pending read response
    send_byte({1'b0, 7'd0});
    @(negedge clk);
    check("t7_pending", 32'(bp_valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(bp_valid_out), 32'd0);
    check("t7_rst_ready", 32'(bp_ready_out), 32'd1);
    check("t7_rst_probe", 32'(probe), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_no_response", 32'(bp_valid_out), 32'd0);
    read_check(7'd1, 8'hA5, "t7_seed_reset");
    read_check(7'd2, 8'h00, "t7_thresh_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
